fixed_linear_weight_streamer: RTL



---
 rtl/fixed_linear_weight_streamer_pkg.sv | 17 +
 rtl/fixed_linear_weight_streamer_tile_regfile.sv | 32 +++
 rtl/fixed_linear_weight_streamer.sv | 112 +++++++++++
 3 files changed

// File: rtl/fixed_linear_weight_streamer_pkg.sv
// linear_layers_pkg: shared types and helpers for the linear-layer feeders.
// Contents:
//   state_e     - streamer control state (LOAD captures a matrix, REPLAY emits it)
//   clog2_min1  - counter width helper that never returns zero bits
package linear_layers_pkg;

    typedef enum logic {
        LOAD   = 1'b0,
        REPLAY = 1'b1
    } state_e;

    // A single-entry range still needs a 1-bit counter to be declarable.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fixed_linear_weight_streamer_tile_regfile.sv
// tile_regfile: NUM_TILES x TILE_SIZE x DATA_WIDTH weight store.
// Ports:
//   clk      - write clock
//   we_i     - write enable for one full tile
//   waddr_i  - tile index written
//   wdata_i  - tile written
//   raddr_i  - tile index read
//   rdata_o  - tile read, combinational from raddr_i
// Contents are not reset; a BRAM-based drop-in would add a read cycle.
module tile_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int TILE_SIZE  = 16,
    parameter int NUM_TILES  = 25,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i [TILE_SIZE],
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o [TILE_SIZE]
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_TILES][TILE_SIZE];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fixed_linear_weight_streamer.sv
// fixed_linear_weight_streamer: captures one weight matrix and replays it REPEAT times.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   in_data    - incoming weight tile (TILE_SIZE elements of DATA_WIDTH)
//   in_valid   - load handshake valid
//   in_ready   - high only while in LOAD
//   out_data   - registered replayed tile
//   out_valid  - output handshake valid
//   out_ready  - downstream ready
//   out_last   - marks the final tile of the final repeat
module fixed_linear_weight_streamer
    import linear_layers_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TILE_SIZE  = 16,
    parameter int NUM_TILES  = 25,
    parameter int REPEAT     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data [TILE_SIZE],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data [TILE_SIZE],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int PW = clog2_min1(NUM_TILES);
    localparam int RW = clog2_min1(REPEAT);
    localparam logic [PW-1:0] PTR_MAX = PW'(NUM_TILES - 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT - 1);

    state_e                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]         rep_cnt_q, rep_cnt_d;
    logic                  armed_q;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q [TILE_SIZE];
    logic [DATA_WIDTH-1:0] rd_tile [TILE_SIZE];
    logic                  in_fire, issue, rd_wrap, rep_done, load_done, final_issue;

    tile_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .TILE_SIZE (TILE_SIZE),
        .NUM_TILES (NUM_TILES),
        .ADDR_W    (PW)
    ) u_regfile (
        .clk    (clk),
        .we_i   (in_fire),
        .waddr_i(wr_ptr_q),
        .wdata_i(in_data),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_tile)
    );

    // Issue waits one settle cycle after entering REPLAY, so the first beat
    // lands two edges after the final load; a registered-read store fits the same slot.
    assign in_fire     = in_valid && in_ready;
    assign issue       = (state_q == REPLAY) && armed_q && (!out_valid_q || out_ready);
    assign rd_wrap     = rd_ptr_q == PTR_MAX;
    assign rep_done    = rep_cnt_q == REP_MAX;
    assign load_done   = in_fire && (wr_ptr_q == PTR_MAX);
    assign final_issue = issue && rd_wrap && rep_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == LOAD) ? (load_done ? REPLAY : LOAD) : (final_issue ? LOAD : REPLAY);
    end

    always_comb begin
        in_ready = state_q == LOAD;
    end

    always_comb begin
        wr_ptr_d    = in_fire ? (load_done ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d    = issue ? (rd_wrap ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        rep_cnt_d   = (issue && rd_wrap) ? (rep_done ? '0 : rep_cnt_q + 1'b1) : rep_cnt_q;
        out_valid_d = issue ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_last_d  = issue ? (rd_wrap && rep_done) : out_last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rep_cnt_q   <= '0;
            armed_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '{default: '0};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rep_cnt_q   <= rep_cnt_d;
            armed_q     <= state_q == REPLAY;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            if (issue) out_data_q <= rd_tile;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule
